// File: rtl/user_proj_counter.sv
// Wishbone user-project counter: COUNT/CTRL/COMPARE/STATUS bank with a compare-match interrupt.
// Build macro COUNTER_LA_LOAD_EN adds a logic-analyzer load path into COUNT.
`ifndef MPRJ_IO_PADS
`define MPRJ_IO_PADS 38
`endif

module user_proj_counter #(
    parameter logic [31:0] COUNT_STEP = 32'd1,
    parameter logic [31:0] COUNT_ADDR = 32'd0,
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     wbs_stb_i,
    input  logic                     wbs_cyc_i,
    input  logic                     wbs_we_i,
    input  logic [3:0]               wbs_sel_i,
    input  logic [31:0]              wbs_dat_i,
    input  logic [31:0]              wbs_adr_i,
    output logic                     wbs_ack_o,
    output logic [31:0]              wbs_dat_o,
    input  logic [31:0]              la_data_in,
    input  logic [31:0]              la_oenb,
    output logic [31:0]              la_data_out,
    input  logic [`MPRJ_IO_PADS-1:0] io_in,
    output logic [`MPRJ_IO_PADS-1:0] io_out,
    output logic [`MPRJ_IO_PADS-1:0] io_oeb,
    input  logic                     user_clock2,
    output logic [2:0]               user_irq
);
    localparam logic [31:0] BANK = BASE_ADDR + (COUNT_ADDR << 4);

    logic [31:0] count_q, compare_q, dat_q;
    logic [1:0]  ctrl_q;
    logic        match_q, ack_q;

    logic        req, wr;
    logic [31:0] rd_data, count_d, compare_d;
    logic [1:0]  ctrl_d;
    logic        match_d;
    logic        unused_inputs;

    function automatic logic [31:0] byte_merge(input logic [31:0] old, input logic [31:0] data,
                                               input logic [3:0] sel);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) res[8*b +: 8] = data[8*b +: 8];
        end
        return res;
    endfunction

    // Handshake: a request is accepted when cyc & stb hit this bank while ack is low;
    // ack is then high for exactly the following cycle, so a held strobe gets one access per two cycles.
    always_comb begin
        req       = wbs_cyc_i & wbs_stb_i & ~ack_q & (wbs_adr_i[31:4] == BANK[31:4]);
        wr        = req & wbs_we_i;
        rd_data   = 32'd0;
        count_d   = count_q;
        ctrl_d    = ctrl_q;
        compare_d = compare_q;
        match_d   = match_q;

        case (wbs_adr_i[3:2])
            2'd0:    rd_data = count_q;
            2'd1:    rd_data = {30'd0, ctrl_q};
            2'd2:    rd_data = compare_q;
            default: rd_data = {31'd0, match_q};
        endcase

        if (ctrl_q[0]) count_d = count_q + COUNT_STEP;
        if (wr && wbs_adr_i[3:2] == 2'd0) count_d = byte_merge(count_q, wbs_dat_i, wbs_sel_i);
`ifdef COUNTER_LA_LOAD_EN
        if (!la_oenb[0]) count_d = la_data_in;
`endif
        if (wr && wbs_adr_i[3:2] == 2'd1 && wbs_sel_i[0]) ctrl_d = wbs_dat_i[1:0];
        if (wr && wbs_adr_i[3:2] == 2'd2) compare_d = byte_merge(compare_q, wbs_dat_i, wbs_sel_i);

        // A match event overrides a write-1-to-clear landing on the same edge.
        if (wr && wbs_adr_i[3:2] == 2'd3 && wbs_sel_i[0] && wbs_dat_i[0]) match_d = 1'b0;
        if (ctrl_q[0] && count_q == compare_q) match_d = 1'b1;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            count_q   <= 32'd0;
            ctrl_q    <= 2'd0;
            compare_q <= 32'd0;
            match_q   <= 1'b0;
            ack_q     <= 1'b0;
            dat_q     <= 32'd0;
        end else begin
            count_q   <= count_d;
            ctrl_q    <= ctrl_d;
            compare_q <= compare_d;
            match_q   <= match_d;
            ack_q     <= req;
            dat_q     <= (req && !wbs_we_i) ? rd_data : 32'd0;
        end
    end

    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = dat_q;
    assign la_data_out = count_q;
    assign user_irq    = {2'b00, match_q & ctrl_q[1]};
    assign io_out      = {count_q[`MPRJ_IO_PADS-9:0], 8'h00};
    assign io_oeb      = {{(`MPRJ_IO_PADS-8){1'b0}}, 8'hFF};

    assign unused_inputs = ^{io_in, user_clock2, la_data_in, la_oenb, wbs_adr_i[1:0]};
endmodule

// File: tb/tb_user_proj_counter.sv
// Bench for user_proj_counter: two instances (step 3 at bank 0x3000_0000, step 1 at bank 0x3000_0010)
// on one Wishbone bus, checked every cycle against a register-array model plus directed literals.
`timescale 1ns/1ps
`ifndef MPRJ_IO_PADS
`define MPRJ_IO_PADS 38
`endif

module tb_user_proj_counter;
    localparam int          PADS   = `MPRJ_IO_PADS;
    localparam logic [31:0] BANK_A = 32'h3000_0000;
    localparam logic [31:0] BANK_B = 32'h3000_0010;
    localparam logic [31:0] STEP_A = 32'd3;
    localparam logic [31:0] STEP_B = 32'd1;

    // clock / reset and bus signals
    logic clk = 1'b0;
    logic rst, stb, cyc, we, user_clock2;
    logic [3:0]  sel;
    logic [31:0] dat_i, adr, la_in, la_oenb;
    logic [PADS-1:0] io_in;

    logic [1:0]            ack;
    logic [1:0][31:0]      dat_o, la_out;
    logic [1:0][PADS-1:0]  io_out, io_oeb;
    logic [1:0][2:0]       irq;

    always #5 clk = ~clk;

    user_proj_counter #(.COUNT_STEP(STEP_A), .COUNT_ADDR(32'd0), .BASE_ADDR(32'h3000_0000)) dut_a (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_dat_i(dat_i), .wbs_adr_i(adr), .wbs_ack_o(ack[0]), .wbs_dat_o(dat_o[0]),
        .la_data_in(la_in), .la_oenb(la_oenb), .la_data_out(la_out[0]),
        .io_in(io_in), .io_out(io_out[0]), .io_oeb(io_oeb[0]),
        .user_clock2(user_clock2), .user_irq(irq[0]));

    user_proj_counter #(.COUNT_STEP(STEP_B), .COUNT_ADDR(32'd1), .BASE_ADDR(32'h3000_0000)) dut_b (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_dat_i(dat_i), .wbs_adr_i(adr), .wbs_ack_o(ack[1]), .wbs_dat_o(dat_o[1]),
        .la_data_in(la_in), .la_oenb(la_oenb), .la_data_out(la_out[1]),
        .io_in(io_in), .io_out(io_out[1]), .io_oeb(io_oeb[1]),
        .user_clock2(user_clock2), .user_irq(irq[1]));

    // scoreboard counters
    int n_cmp = 0;
    int n_bad = 0;
    logic chk_on = 1'b0;

    task automatic check(input string name, input int unit, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %h, expected %h at %0t", name, unit, act, exp, $time);
        end
    endtask

    // Behavioural model: registers indexed by word offset (0 COUNT, 1 CTRL, 2 COMPARE, 3 STATUS).
    logic [31:0] m_reg [2][4];
    logic        m_ack [2];
    logic [31:0] m_dat [2];

    function automatic logic [31:0] sel_merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (old & ~mask) | (d & mask);
    endfunction

    task automatic model_step(input int i);
        logic [31:0] bank, step, wv;
        logic [31:0] old [4];
        logic [31:0] nxt [4];
        logic hit, en, hit_match;
        int k;
        bank = (i == 0) ? BANK_A : BANK_B;
        step = (i == 0) ? STEP_A : STEP_B;
        if (rst) begin
            for (int r = 0; r < 4; r++) m_reg[i][r] = 32'd0;
            m_ack[i] = 1'b0;
            m_dat[i] = 32'd0;
            return;
        end
        for (int r = 0; r < 4; r++) begin
            old[r] = m_reg[i][r];
            nxt[r] = m_reg[i][r];
        end
        en        = old[1][0];
        hit_match = en && (old[0] == old[2]);
        nxt[0]    = old[0] + (en ? step : 32'd0);
        hit       = cyc && stb && !m_ack[i] && (adr[31:4] == bank[31:4]);
        k         = int'(adr[3:2]);
        if (hit && we) begin
            wv = sel_merge(old[k], dat_i, sel);
            case (k)
                0: nxt[0] = wv;
                1: nxt[1] = wv & 32'h3;
                2: nxt[2] = wv;
                default: if (sel[0] && dat_i[0]) nxt[3] = 32'd0;
            endcase
        end
        if (hit_match) nxt[3] = 32'd1;
`ifdef COUNTER_LA_LOAD_EN
        if (!la_oenb[0]) nxt[0] = la_in;
`endif
        m_dat[i] = (hit && !we) ? old[k] : 32'd0;
        m_ack[i] = hit;
        for (int r = 0; r < 4; r++) m_reg[i][r] = nxt[r];
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) model_step(i);
    end

    // per-cycle compare of every output of both instances
    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 2; i++) begin
                logic [63:0] t, a64, e64;
                check("ack", i, 64'(ack[i]), 64'(m_ack[i]));
                check("dat_o", i, 64'(dat_o[i]), 64'(m_dat[i]));
                check("la_data_out", i, 64'(la_out[i]), 64'(m_reg[i][0]));
                check("user_irq", i, 64'(irq[i]), 64'({2'b00, m_reg[i][3][0] & m_reg[i][1][1]}));
                t = {24'd0, m_reg[i][0], 8'd0};
                a64 = '0; a64[PADS-1:0] = io_out[i];
                e64 = '0; e64[PADS-1:0] = t[PADS-1:0];
                check("io_out", i, a64, e64);
                a64 = '0; a64[PADS-1:0] = io_oeb[i];
                e64 = '0; e64[7:0] = 8'hFF;
                check("io_oeb", i, a64, e64);
            end
        end
    end

    // driver tasks
    task automatic wb(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rdata, output logic [1:0] acks);
        @(negedge clk);
        adr = a; we = w; dat_i = d; sel = s; cyc = 1'b1; stb = 1'b1;
        @(negedge clk);
        acks  = ack;
        rdata = dat_o[0] | dat_o[1];
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r; logic [1:0] k;
        wb(a, 1'b1, d, 4'hF, r, k);
    endtask

    task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] r; logic [1:0] k;
        wb(a, 1'b0, 32'd0, 4'hF, r, k);
        check(name, 0, 64'(r), 64'(exp));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [1:0]  k;
        int          acks_seen;
        logic        found;
        rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; dat_i = '0; adr = '0;
        la_in = '0; la_oenb = '1; io_in = '0; user_clock2 = 1'b0;
        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // reset state
        rd_check("rst_count", BANK_A + 32'h0, 32'd0);
        rd_check("rst_ctrl", BANK_A + 32'h4, 32'd0);
        rd_check("rst_compare", BANK_A + 32'h8, 32'd0);
        rd_check("rst_status", BANK_A + 32'hC, 32'd0);

        // step 3: six enabled edges between enable and disable give 18
        wr(BANK_A + 32'h4, 32'h1);
        idle(4);
        wr(BANK_A + 32'h4, 32'h0);
        rd_check("step3_count", BANK_A, 32'd18);
        rd_check("ctrl_readback", BANK_A + 32'h4, 32'd0);

        // wrap modulo 2^32
        wr(BANK_A, 32'hFFFF_FFFE);
        wr(BANK_A + 32'h4, 32'h1);
        check("pre_wrap", 0, 64'(la_out[0]), 64'(32'hFFFF_FFFE));
        @(negedge clk);
        check("wrap", 0, 64'(la_out[0]), 64'(32'h0000_0001));
        wr(BANK_A + 32'h4, 32'h0);

        // byte-enable write
        wr(BANK_A, 32'h0);
        begin
            wb(BANK_A, 1'b1, 32'hAABB_CCDD, 4'b0010, r, k);
        end
        rd_check("byte_write", BANK_A, 32'h0000_CC00);
        rd_check("ctrl_upper_zero", BANK_A + 32'h4, 32'd0);

        // compare match + IRQ on instance B (step 1)
        wr(BANK_B, 32'h0C);
        wr(BANK_B + 32'h8, 32'h10);
        wr(BANK_B + 32'h4, 32'h3);
        found = 1'b0;
        for (int c = 0; c < 64 && !found; c++) begin
            if (la_out[1] == 32'h10) found = 1'b1;
            else @(negedge clk);
        end
        check("match_reached", 1, 64'(found), 64'(1));
        check("irq_before", 1, 64'(irq[1]), 64'(3'b000));
        @(negedge clk);
        check("irq_after", 1, 64'(irq[1]), 64'(3'b001));

        // set wins over simultaneous W1C
        wr(BANK_B + 32'hC, 32'h1);
        wr(BANK_B, 32'h0F);
        wr(BANK_B + 32'hC, 32'h1);
        wb(BANK_B + 32'hC, 1'b0, 32'd0, 4'hF, r, k);
        check("set_wins", 1, 64'(r), 64'(1));
        wr(BANK_B + 32'hC, 32'h1);
        wb(BANK_B + 32'hC, 1'b0, 32'd0, 4'hF, r, k);
        check("w1c_clear", 1, 64'(r), 64'(0));
        wr(BANK_B + 32'h4, 32'h0);

        // out-of-bank accesses
        wb(32'h300F_FFFC, 1'b0, 32'd0, 4'hF, r, k);
        check("oob_fffc", 0, 64'(k), 64'(2'b00));
        wb(32'h3000_0020, 1'b1, 32'h1, 4'hF, r, k);
        check("oob_20", 0, 64'(k), 64'(2'b00));
        wb(BANK_A + 32'h10, 1'b0, 32'd0, 4'hF, r, k);
        check("bank_plus_10", 0, 64'(k), 64'(2'b10));

        // throughput: held strobe gives an ack every other cycle
        @(negedge clk);
        adr = BANK_A + 32'h8; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        acks_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack[0]) acks_seen++;
        end
        cyc = 1'b0; stb = 1'b0;
        check("throughput", 0, 64'(acks_seen), 64'(3));

        // reset on the request cycle
        wr(BANK_A + 32'h8, 32'h77);
        wr(BANK_A + 32'h4, 32'h2);
        wr(BANK_A, 32'h99);
        @(negedge clk);
        adr = BANK_A; we = 1'b1; dat_i = 32'h55; sel = 4'hF; cyc = 1'b1; stb = 1'b1; rst = 1'b1;
        @(negedge clk);
        check("rst_no_ack", 0, 64'(ack), 64'(2'b00));
        cyc = 1'b0; stb = 1'b0; we = 1'b0; rst = 1'b0;
        @(negedge clk);
        check("rst_no_ack_late", 0, 64'(ack), 64'(2'b00));
        rd_check("rst2_count", BANK_A, 32'd0);
        rd_check("rst2_ctrl", BANK_A + 32'h4, 32'd0);
        rd_check("rst2_compare", BANK_A + 32'h8, 32'd0);

`ifdef COUNTER_LA_LOAD_EN
        // LA load beats a simultaneous Wishbone write
        @(negedge clk);
        la_in = 32'h1234; la_oenb = 32'hFFFF_FFFE;
        wr(BANK_A, 32'h55);
        la_oenb = '1;
        rd_check("la_load", BANK_A, 32'h1234);
`endif

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a, d;
            case ($urandom_range(0, 9))
                0: a = 32'h300F_FFFC;
                1: a = 32'h3000_0020;
                2: a = $urandom();
                default: a = ($urandom_range(0, 1) ? BANK_B : BANK_A) + 32'($urandom_range(0, 15));
            endcase
            d = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 40)) : $urandom();
            la_in   = $urandom();
`ifdef COUNTER_LA_LOAD_EN
            la_oenb = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF;
`else
            la_oenb = $urandom();
`endif
            io_in   = PADS'($urandom());
            wb(a, 1'($urandom_range(0, 1)), d, 4'($urandom_range(0, 15)), r, k);
            idle($urandom_range(0, 3));
            if ($urandom_range(0, 59) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
